rule_scan_controller: RTL and testbench
=======================================

Name: rule_scan_controller

Overview:
Sequential first-match classifier for the packet-filter datapath. Holds a table of NUM_RULES range rules (rule_s) and accepts one packet_s at a time over a valid/ready handshake. It scans the valid rules in index order, one rule per cycle, and returns the lowest matching rule index, or a miss, over a second valid/ready handshake. Rule table writes share the block's idle window, so the table is never modified mid-scan.

Parameters:
NUM_RULES, 16, number of rule slots (power of two, ≥2)
IDX_W, $clog2(NUM_RULES), rule index width (derived localparam; not overridable)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
rule_wr_valid  input  1  rule write request
rule_wr_ready  output  1  write accepted this cycle (high only in IDLE)
rule_wr_idx  input  IDX_W  slot to write
rule_wr_en  input  1  1 = write rule and mark slot valid; 0 = invalidate slot
rule_wr_data  input  $bits(rule_s)  rule value (start/last bounds)
pkt_valid  input  1  packet offered
pkt_ready  output  1  packet accepted this cycle
pkt_data  input  $bits(packet_s)  packet header
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_hit  output  1  1 = a rule matched
res_idx  output  IDX_W  lowest matching index (0 on miss)
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_in sampled high at a clk_in edge): state IDLE, all rule-valid bits cleared, scan index 0, res_valid=0, res_hit=0, res_idx=0. Rule contents are don't-care. Reset mid-scan or mid-result drops the packet and result silently.
- Clock and reset: single clk_in domain. Reset is synchronous and active-high on rst_in. No asynchronous reset anywhere.
- Match rule: a packet matches rule r when the slot is valid and, for each of src.ip, src.port, dst.ip, dst.port and protocol, start.f ≤ pkt.f ≤ last.f. Comparisons are unsigned and inclusive. A rule with start.f > last.f for any field never matches.
- FSM states:
  - IDLE
    - pkt_ready=1 and rule_wr_ready=1.
    - If rule_wr_valid: write the slot. rule_wr_en=1 stores rule_wr_data and sets valid; rule_wr_en=0 clears valid. The write takes effect at the edge.
    - If pkt_valid: capture pkt_data, set idx=0, go to SCAN.
    - A write and a packet in the same cycle are both accepted. The scan sees the written rule, because rule 0 is evaluated the cycle after capture.
  - SCAN
    - pkt_ready=0, rule_wr_ready=0. Evaluate rule[idx] combinationally against the captured packet.
    - On hit: res_hit←1, res_idx←idx, go to RESULT.
    - Else if idx==NUM_RULES-1: res_hit←0, res_idx←0, go to RESULT.
    - Else idx←idx+1.
    - Invalid slots still cost one cycle. There is no skip-ahead.
  - RESULT
    - res_valid=1, with res_hit and res_idx held stable.
    - When res_ready=1: go to IDLE at that edge, and res_valid=0 the following cycle.
    - A new packet cannot be accepted in the same cycle as the result handshake.
- Latency, counted from the pkt handshake edge E:
  - hit at index k: res_valid is high in the cycle after edge E+k+1.
  - miss: res_valid is high after edge E+NUM_RULES.
  - Minimum packet-to-packet spacing is therefore k+3 cycles (hit) and NUM_RULES+2 cycles (miss).
- idx wraps never; scan termination is explicit. With an empty table, every packet misses after a full scan.
- Inputs are ignored while their ready is low. Writes offered outside IDLE wait: rule_wr_valid must be held until rule_wr_ready.

Decomposition:
- Shared network_pkg additions: RULE_BITS = $bits(rule_s), PACKET_BITS = $bits(packet_s), and scan_state_e enum {IDLE, SCAN, RESULT}.
- Sub-module rule_field_check: purely combinational, rule_s + packet_s in → 1-bit match out. Performs the five inclusive range compares. Reused by any future parallel classifier.
- Rule storage is a register array plus a NUM_RULES-bit valid vector, both inside rule_scan_controller.

Test Plan:
- Reset then packet {src 10.0.0.1:80, dst 10.0.0.2:443, proto 6} with an empty table -> res_valid after 16 scan cycles, res_hit=0, res_idx=0.
- Write rule 3 as full wildcard (start all-zero, last all-ones), send any packet -> res_hit=1, res_idx=3, res_valid 4 cycles after acceptance.
- Rules 2 and 5 both match (port range 80..80 and 0..65535) -> res_idx=2. Invalidate slot 2 (rule_wr_en=0) and resend -> res_idx=5.
- Boundary checks with rule proto 6..6 and dst.port 443..443:
  - packet with port 443 -> hit.
  - port 444 -> miss.
  - port 442 -> miss.
  - rule with start.ip=10.0.0.9 > last.ip=10.0.0.1 -> never hits.
- Hold res_ready=0 for 5 cycles -> res_valid, res_hit and res_idx stable; pkt_ready=0 throughout. A rule write offered during SCAN stalls (rule_wr_ready=0) and lands in IDLE.
- Assert rst_in during SCAN at idx 7 -> next cycle IDLE, res_valid=0, pkt_ready=1, all slots invalid (a subsequent wildcard-free packet misses).

Source files
------------

// File: rtl/rule_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rule_scan_controller_pkg
// Description : Shared types for the packet-filter rule scanner: packet and
//               rule records, their flattened widths, and the scan FSM states.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rule_scan_controller_pkg;

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] port;
  } endpoint_s;

  typedef struct packed {
    endpoint_s   src;
    endpoint_s   dst;
    logic [7:0]  protocol;
  } packet_s;

  // Inclusive per-field bounds: a packet matches when start <= field <= last.
  typedef struct packed {
    packet_s start;
    packet_s last;
  } rule_s;

  localparam int RULE_BITS   = $bits(rule_s);
  localparam int PACKET_BITS = $bits(packet_s);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/rule_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : rule_scan_controller_if
// Description : Bundles the rule-write, packet and result handshakes of the
//               rule scanner. The master drives requests and res_ready; the
//               slave (the scanner) drives the readies, result and busy.
// Ports       : rule_wr_* (rule table write), pkt_* (packet in),
//               res_* (classification out), busy (scanner not idle)
// Revision    : 1.0 - initial release
// ============================================================================
interface rule_scan_controller_if
  import rule_scan_controller_pkg::*;
#(
  parameter int NUM_RULES = 16
) ();

  localparam int IDX_W = $clog2(NUM_RULES);

  logic                   rule_wr_valid;
  logic                   rule_wr_ready;
  logic [IDX_W-1:0]       rule_wr_idx;
  logic                   rule_wr_en;
  logic [RULE_BITS-1:0]   rule_wr_data;
  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [PACKET_BITS-1:0] pkt_data;
  logic                   res_valid;
  logic                   res_ready;
  logic                   res_hit;
  logic [IDX_W-1:0]       res_idx;
  logic                   busy;

  modport master (
    output rule_wr_valid, rule_wr_idx, rule_wr_en, rule_wr_data,
    output pkt_valid, pkt_data, res_ready,
    input  rule_wr_ready, pkt_ready, res_valid, res_hit, res_idx, busy
  );

  modport slave (
    input  rule_wr_valid, rule_wr_idx, rule_wr_en, rule_wr_data,
    input  pkt_valid, pkt_data, res_ready,
    output rule_wr_ready, pkt_ready, res_valid, res_hit, res_idx, busy
  );

endinterface
`default_nettype wire

// File: rtl/rule_scan_controller_check.sv
`default_nettype none
// ============================================================================
// Module      : rule_field_check
// Description : Purely combinational range match of one packet against one
//               rule. All five fields are compared unsigned and inclusive; a
//               field whose start exceeds its last can never match.
// Ports       : rule_i  - rule bounds
//               pkt_i   - packet header
//               match_o - 1 when every field lies within its bounds
// Revision    : 1.0 - initial release
// ============================================================================
module rule_field_check
  import rule_scan_controller_pkg::*;
(
  input  rule_s   rule_i,
  input  packet_s pkt_i,
  output logic    match_o
);

  logic w_src_ip_ok;
  logic w_src_port_ok;
  logic w_dst_ip_ok;
  logic w_dst_port_ok;
  logic w_proto_ok;

  always_comb begin
    w_src_ip_ok   = (rule_i.start.src.ip   <= pkt_i.src.ip)   &&
                    (pkt_i.src.ip          <= rule_i.last.src.ip);
    w_src_port_ok = (rule_i.start.src.port <= pkt_i.src.port) &&
                    (pkt_i.src.port        <= rule_i.last.src.port);
    w_dst_ip_ok   = (rule_i.start.dst.ip   <= pkt_i.dst.ip)   &&
                    (pkt_i.dst.ip          <= rule_i.last.dst.ip);
    w_dst_port_ok = (rule_i.start.dst.port <= pkt_i.dst.port) &&
                    (pkt_i.dst.port        <= rule_i.last.dst.port);
    w_proto_ok    = (rule_i.start.protocol <= pkt_i.protocol) &&
                    (pkt_i.protocol        <= rule_i.last.protocol);
    match_o = w_src_ip_ok && w_src_port_ok && w_dst_ip_ok &&
              w_dst_port_ok && w_proto_ok;
  end

endmodule
`default_nettype wire

// File: rtl/rule_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : rule_scan_controller
// Description : Sequential first-match packet classifier. Holds NUM_RULES
//               range rules, accepts one packet at a time, scans the slots in
//               index order at one rule per cycle and returns the lowest
//               matching index or a miss. Rule writes are only accepted while
//               idle, so the table is stable for the duration of a scan.
// Ports       : clk_in - system clock
//               rst_in - synchronous active-high reset
//               bus    - slave side of rule_scan_controller_if (rule write,
//                        packet and result handshakes, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module rule_scan_controller
  import rule_scan_controller_pkg::*;
#(
  parameter int NUM_RULES = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  rule_scan_controller_if.slave        bus
);

  localparam int               IDX_W    = $clog2(NUM_RULES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RULES - 1);

  scan_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 res_hit_q, res_hit_d;
  logic [IDX_W-1:0]     res_idx_q, res_idx_d;
  packet_s              pkt_q;
  rule_s                rules_q [NUM_RULES];
  logic [NUM_RULES-1:0] valid_q;

  rule_s                w_wr_rule;
  packet_s              w_pkt_in;
  logic                 w_idle;
  logic                 w_wr_fire;
  logic                 w_pkt_fire;
  logic                 w_rule_match;
  logic                 w_hit;

  assign w_wr_rule  = rule_s'(bus.rule_wr_data);
  assign w_pkt_in   = packet_s'(bus.pkt_data);
  assign w_idle     = (state_q == IDLE);
  // Both handshakes may complete in the same idle cycle; the scan starts on
  // rule 0 one cycle later, so it already sees the freshly written slot.
  assign w_wr_fire  = w_idle && bus.rule_wr_valid;
  assign w_pkt_fire = w_idle && bus.pkt_valid;

  rule_field_check u_check (
    .rule_i  (rules_q[idx_q]),
    .pkt_i   (pkt_q),
    .match_o (w_rule_match)
  );

  assign w_hit = w_rule_match && valid_q[idx_q];

  // Rule contents and the captured packet carry no reset: only the valid
  // vector decides whether a slot can match.
  always_ff @(posedge clk_in) begin
    if (w_wr_fire && bus.rule_wr_en) begin
      rules_q[bus.rule_wr_idx] <= w_wr_rule;
    end
    if (w_pkt_fire) begin
      pkt_q <= w_pkt_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      res_hit_q <= 1'b0;
      res_idx_q <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      res_hit_q <= res_hit_d;
      res_idx_q <= res_idx_d;
      if (w_wr_fire) begin
        valid_q[bus.rule_wr_idx] <= bus.rule_wr_en;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    res_hit_d = res_hit_q;
    res_idx_d = res_idx_q;
    case (state_q)
      IDLE: begin
        if (bus.pkt_valid) begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (w_hit) begin
          res_hit_d = 1'b1;
          res_idx_d = idx_q;
          state_d   = RESULT;
        end else if (idx_q == LAST_IDX) begin
          // Explicit termination on the last slot; the index never wraps.
          res_hit_d = 1'b0;
          res_idx_d = '0;
          state_d   = RESULT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.pkt_ready     = w_idle;
  assign bus.rule_wr_ready = w_idle;
  assign bus.res_valid     = (state_q == RESULT);
  assign bus.res_hit       = res_hit_q;
  assign bus.res_idx       = res_idx_q;
  assign bus.busy          = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_rule_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_rule_scan_controller
// Description : Self-checking bench for rule_scan_controller: directed
//               sequences, a boundary vector table, and random traffic scored
//               against a first-match reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rule_scan_controller;
  import rule_scan_controller_pkg::*;

  localparam int NUM_RULES = 16;
  localparam int TIMEOUT   = 64;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  rule_scan_controller_if #(.NUM_RULES(NUM_RULES)) bus ();

  rule_scan_controller #(.NUM_RULES(NUM_RULES)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int    checks   = 0;
  int    failures = 0;
  logic  model_valid [NUM_RULES];
  rule_s model_rule  [NUM_RULES];

  typedef struct {
    packet_s    pkt;
    logic       hit;
    logic [3:0] idx;
    int         lat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic packet_s mk_pkt(input logic [31:0] sip, input logic [15:0] sp,
                                     input logic [31:0] dip, input logic [15:0] dp,
                                     input logic [7:0] pr);
    packet_s p;
    p.src.ip   = sip;
    p.src.port = sp;
    p.dst.ip   = dip;
    p.dst.port = dp;
    p.protocol = pr;
    return p;
  endfunction

  function automatic rule_s wild();
    rule_s r;
    r.start = '0;
    r.last  = '1;
    return r;
  endfunction

  // Reference: first valid slot whose every field lies in [start, last].
  function automatic bit fits(input rule_s r, input packet_s p);
    longint unsigned lo [5];
    longint unsigned hi [5];
    longint unsigned v  [5];
    lo = '{64'(r.start.src.ip), 64'(r.start.src.port), 64'(r.start.dst.ip),
           64'(r.start.dst.port), 64'(r.start.protocol)};
    hi = '{64'(r.last.src.ip), 64'(r.last.src.port), 64'(r.last.dst.ip),
           64'(r.last.dst.port), 64'(r.last.protocol)};
    v  = '{64'(p.src.ip), 64'(p.src.port), 64'(p.dst.ip), 64'(p.dst.port), 64'(p.protocol)};
    for (int f = 0; f < 5; f++) begin
      if (v[f] < lo[f] || v[f] > hi[f]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_classify(input packet_s p, output logic hit, output logic [3:0] idx);
    hit = 1'b0;
    idx = 4'd0;
    for (int r = 0; r < NUM_RULES; r++) begin
      if (!hit && model_valid[r] && fits(model_rule[r], p)) begin
        hit = 1'b1;
        idx = 4'(r);
      end
    end
  endtask

  task automatic tb_write(input int idx, input logic en, input rule_s r);
    int n = 0;
    bus.rule_wr_valid = 1'b1;
    bus.rule_wr_idx   = 4'(idx);
    bus.rule_wr_en    = en;
    bus.rule_wr_data  = r;
    while (!bus.rule_wr_ready && n < TIMEOUT) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("wr_ready", 32'(bus.rule_wr_ready), 32'd1);
    @(posedge clk_in); #1;
    bus.rule_wr_valid = 1'b0;
    model_valid[idx] = en;
    if (en) model_rule[idx] = r;
  endtask

  task automatic run_pkt(input packet_s p, input int hold, input logic exp_hit,
                         input logic [3:0] exp_idx, input int exp_lat, input string tag);
    int n = 0;
    while (!bus.pkt_ready && n < TIMEOUT) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk({tag, "_pkt_ready"}, 32'(bus.pkt_ready), 32'd1);
    bus.pkt_data  = p;
    bus.pkt_valid = 1'b1;
    @(posedge clk_in); #1;
    bus.pkt_valid = 1'b0;
    n = 0;
    while (!bus.res_valid && n < TIMEOUT) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_hit"}, 32'(bus.res_hit), 32'(exp_hit));
    chk({tag, "_idx"}, 32'(bus.res_idx), 32'(exp_idx));
    repeat (hold) begin
      @(posedge clk_in); #1;
      chk({tag, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
      chk({tag, "_hold_idx"}, 32'(bus.res_idx), 32'(exp_idx));
    end
    bus.res_ready = 1'b1;
    @(posedge clk_in); #1;
    bus.res_ready = 1'b0;
    chk({tag, "_drop"}, 32'(bus.res_valid), 32'd0);
  endtask

  function automatic rule_s rand_rule();
    rule_s r = wild();
    if ($urandom_range(1, 0) == 1) begin
      r.start.src.ip = 32'h0A00_0000 + $urandom_range(3, 0);
      r.last.src.ip  = 32'h0A00_0000 + $urandom_range(3, 0);
    end
    if ($urandom_range(1, 0) == 1) begin
      r.start.dst.port = 16'($urandom_range(3, 0));
      r.last.dst.port  = 16'($urandom_range(3, 0));
    end
    if ($urandom_range(1, 0) == 1) begin
      r.start.protocol = 8'($urandom_range(3, 0));
      r.last.protocol  = 8'($urandom_range(3, 0));
    end
    if ($urandom_range(3, 0) == 0) begin
      r.start.src.port = 16'($urandom_range(3, 0));
      r.last.src.port  = 16'($urandom_range(3, 0));
    end
    return r;
  endfunction

  function automatic packet_s rand_pkt();
    return mk_pkt(32'h0A00_0000 + $urandom_range(3, 0), 16'($urandom_range(3, 0)),
                  32'h0A00_0002, 16'($urandom_range(3, 0)), 8'($urandom_range(3, 0)));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    packet_s    p0, p1, pr;
    rule_s      r;
    logic       m_hit;
    logic [3:0] m_idx;
    int         n;

    bus.rule_wr_valid = 1'b0;
    bus.rule_wr_idx   = '0;
    bus.rule_wr_en    = 1'b0;
    bus.rule_wr_data  = '0;
    bus.pkt_valid     = 1'b0;
    bus.pkt_data      = '0;
    bus.res_ready     = 1'b0;
    for (int i = 0; i < NUM_RULES; i++) begin
      model_valid[i] = 1'b0;
      model_rule[i]  = wild();
    end

    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;

    chk("rst_pkt_ready", 32'(bus.pkt_ready), 32'd1);
    chk("rst_wr_ready", 32'(bus.rule_wr_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_hit", 32'(bus.res_hit), 32'd0);
    chk("rst_res_idx", 32'(bus.res_idx), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // Empty table: full scan, miss.
    p0 = mk_pkt(32'h0A00_0001, 16'd80, 32'h0A00_0002, 16'd443, 8'd6);
    run_pkt(p0, 0, 1'b0, 4'd0, NUM_RULES, "empty");

    // Wildcard in slot 3.
    tb_write(3, 1'b1, wild());
    run_pkt(p0, 0, 1'b1, 4'd3, 4, "wild3");
    tb_write(3, 1'b0, wild());

    // Lowest index wins; invalidation exposes the next match.
    r = wild(); r.start.dst.port = 16'd80; r.last.dst.port = 16'd80;
    tb_write(2, 1'b1, r);
    r = wild(); r.start.dst.port = 16'd0; r.last.dst.port = 16'hFFFF;
    tb_write(5, 1'b1, r);
    p1 = mk_pkt(32'h0A00_0001, 16'd1234, 32'h0A00_0002, 16'd80, 8'd6);
    run_pkt(p1, 0, 1'b1, 4'd2, 3, "first2");
    tb_write(2, 1'b0, wild());
    run_pkt(p1, 0, 1'b1, 4'd5, 6, "first5");
    tb_write(5, 1'b0, wild());

    // Boundary table: slot 1 = proto 6..6 and dst.port 443..443,
    // slot 4 = inverted src.ip bounds (never matches).
    r = wild();
    r.start.protocol = 8'd6;    r.last.protocol = 8'd6;
    r.start.dst.port = 16'd443; r.last.dst.port = 16'd443;
    tb_write(1, 1'b1, r);
    r = wild();
    r.start.src.ip = 32'h0A00_0009; r.last.src.ip = 32'h0A00_0001;
    tb_write(4, 1'b1, r);

    vecs[0] = '{mk_pkt(32'h0A00_0001, 16'd80, 32'h0A00_0002, 16'd443, 8'd6), 1'b1, 4'd1, 2};
    vecs[1] = '{mk_pkt(32'h0A00_0001, 16'd80, 32'h0A00_0002, 16'd444, 8'd6), 1'b0, 4'd0, 16};
    vecs[2] = '{mk_pkt(32'h0A00_0001, 16'd80, 32'h0A00_0002, 16'd442, 8'd6), 1'b0, 4'd0, 16};
    vecs[3] = '{mk_pkt(32'h0A00_0001, 16'd80, 32'h0A00_0002, 16'd443, 8'd7), 1'b0, 4'd0, 16};
    vecs[4] = '{mk_pkt(32'h0A00_0005, 16'd9,  32'h0A00_0003, 16'd443, 8'd6), 1'b1, 4'd1, 2};
    vecs[5] = '{mk_pkt(32'h0A00_0009, 16'd80, 32'h0A00_0002, 16'd444, 8'd6), 1'b0, 4'd0, 16};
    for (int i = 0; i < 6; i++) begin
      run_pkt(vecs[i].pkt, 0, vecs[i].hit, vecs[i].idx, vecs[i].lat, $sformatf("vec%0d", i));
    end
    tb_write(1, 1'b0, wild());
    tb_write(4, 1'b0, wild());

    // Write offered mid-scan must stall until IDLE; result held under backpressure.
    tb_write(9, 1'b1, wild());
    bus.pkt_data  = p0;
    bus.pkt_valid = 1'b1;
    @(posedge clk_in); #1;
    bus.pkt_valid     = 1'b0;
    bus.rule_wr_valid = 1'b1;
    bus.rule_wr_idx   = 4'd9;
    bus.rule_wr_en    = 1'b0;
    bus.rule_wr_data  = '0;
    n = 0;
    while (!bus.res_valid && n < TIMEOUT) begin
      chk("stall_wr_ready", 32'(bus.rule_wr_ready), 32'd0);
      @(posedge clk_in); #1;
      n++;
    end
    chk("stall_lat", n, 10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in); #1;
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_hit", 32'(bus.res_hit), 32'd1);
      chk("hold_idx", 32'(bus.res_idx), 32'd9);
      chk("hold_pkt_ready", 32'(bus.pkt_ready), 32'd0);
      chk("hold_wr_ready", 32'(bus.rule_wr_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk_in); #1;
    bus.res_ready = 1'b0;
    chk("hold_drop", 32'(bus.res_valid), 32'd0);
    chk("late_wr_ready", 32'(bus.rule_wr_ready), 32'd1);
    @(posedge clk_in); #1;
    bus.rule_wr_valid = 1'b0;
    model_valid[9] = 1'b0;
    run_pkt(p0, 0, 1'b0, 4'd0, NUM_RULES, "late_wr");

    // Reset while scanning index 7 clears everything.
    tb_write(12, 1'b1, wild());
    bus.pkt_data  = p0;
    bus.pkt_valid = 1'b1;
    @(posedge clk_in); #1;
    bus.pkt_valid = 1'b0;
    repeat (7) begin
      @(posedge clk_in); #1;
    end
    chk("midscan_busy", 32'(bus.busy), 32'd1);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    chk("mrst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("mrst_pkt_ready", 32'(bus.pkt_ready), 32'd1);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_res_idx", 32'(bus.res_idx), 32'd0);
    for (int i = 0; i < NUM_RULES; i++) model_valid[i] = 1'b0;
    run_pkt(p0, 0, 1'b0, 4'd0, NUM_RULES, "post_rst");

    // Random traffic against the reference model.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(2, 0) == 0) begin
        tb_write(int'($urandom_range(NUM_RULES - 1, 0)), ($urandom_range(3, 0) != 0), rand_rule());
      end else begin
        pr = rand_pkt();
        model_classify(pr, m_hit, m_idx);
        run_pkt(pr, int'($urandom_range(2, 0)), m_hit, m_idx,
                m_hit ? int'(m_idx) + 1 : NUM_RULES, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
